uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised, prescaled UART transmitter for the serial subsystem. It accepts a parallel word through a valid/ready handshake and serialises it LSB-first on `TX_OUT` as start, data, optional parity and one or two stop bits. Each bit lasts a programmable number of clock cycles. A one-entry holding register lets the next word be accepted while the current frame is on the line, so back-to-back frames leave no idle gap.

## Interface

**Parameters**

- `DATA_WIDTH`, default 8: data bits per frame, legal range 5–9.
- `PRESCALE_WIDTH`, default 6: width of the `PRESCALE` input.

**Ports**

One clock; reset is asynchronous and active-high.

- `CLK` in, 1: rising-edge clock.
- `RST` in, 1: asynchronous, active-high reset.
- `P_DATA` in, `DATA_WIDTH`: word to transmit.
- `Data_Valid` in, 1: `P_DATA` and the frame configuration inputs are valid.
- `Data_Ready` out, 1: the holding register is empty and can accept a word.
- `PAR_EN` in, 1: 1 inserts a parity bit.
- `PAR_TYP` in, 1: 0 selects even parity, 1 selects odd parity.
- `STP2` in, 1: 1 sends two stop bits, 0 sends one.
- `PRESCALE` in, `PRESCALE_WIDTH`: clock cycles per bit. A value of 0 is treated as 1.
- `TX_OUT` out, 1: serial line, idles high.
- `busy` out, 1: a frame is on the line.

## Operation

**Handshake**
- A word is accepted at a rising edge where `Data_Valid` and `Data_Ready` are both 1.
- On acceptance, `P_DATA`, `PAR_EN`, `PAR_TYP` and `STP2` are captured into the holding register.
- `Data_Valid` while `Data_Ready` is 0 is ignored. Upstream holds its data until accepted.
- Changes to the inputs after acceptance do not affect the captured frame.

**State machine:** IDLE → START → DATA → PARITY → STOP1 → STOP2.
- IDLE with the holding register full: load the shifter and parity bit, clear the holding register, go to START.
- START → DATA.
- DATA → PARITY after `DATA_WIDTH` bits if `PAR_EN` is 1, otherwise → STOP1.
- PARITY → STOP1.
- STOP1 → STOP2 if `STP2` is 1, otherwise end of frame.
- STOP2 → end of frame.
- End of frame: go to START if the holding register is full (no idle cycle), otherwise go to IDLE.

**Bit timing**
- Each state lasts P = max(`PRESCALE`, 1) cycles, counted by a prescale counter.
- `PRESCALE` is sampled when the frame enters START and held for the whole frame.

**Bit values**
- `TX_OUT` is registered: 1 in IDLE, STOP1 and STOP2; 0 in START.
- In DATA, `TX_OUT` carries data bit i in the i-th data slot, LSB first.
- Parity bit = XOR of the data bits, inverted when `PAR_TYP` is 1.

**Frame length** = (2 + `DATA_WIDTH` + `PAR_EN` + `STP2`) × P cycles.

## Timing

**Reset values:** `TX_OUT`=1, `busy`=0, `Data_Ready`=1, state IDLE, holding register empty.

**Latency from IDLE**
- Accept at edge k sets `Data_Ready`=0 after k.
- At edge k+1: `TX_OUT`=0 (start bit), `busy`=1, `Data_Ready`=1.

**`busy`**
- Rises with the start bit and falls at the edge that returns to IDLE.
- Stays 1 continuously across back-to-back frames.

**Holding register**
- Drains at frame start. At most one word is pending beyond the one on the line.
- Acceptance and drain never coincide: `Data_Ready` is 0 whenever the register is full.

**Reset mid-frame**
- Asserting `RST` forces `TX_OUT`=1, `busy`=0 and `Data_Ready`=1 immediately, with no clock edge needed.
- The current frame and any pending word are discarded.

**Reset release:** the first edge after `RST` deasserts behaves as IDLE.

## Test plan

- **Even parity, P=1:** `P_DATA`=0x78, `PAR_EN`=1, `PAR_TYP`=0, `STP2`=0, `PRESCALE`=1 → `TX_OUT` = 0, 0,0,0,1,1,1,1,0, 0, 1; `busy` high for exactly 11 cycles, starting 1 cycle after acceptance.
- **Odd parity, P=4:** `P_DATA`=0x70, `PAR_EN`=1, `PAR_TYP`=1, `PRESCALE`=4 → data 0,0,0,0,1,1,1,0, parity 0; every level held 4 cycles; `busy` high for 44 cycles.
- **No parity, two stop bits, P=0:** `P_DATA`=0x60, `PAR_EN`=0, `STP2`=1, `PRESCALE`=0 → behaves as P=1; `TX_OUT` = 0, 0,0,0,0,0,1,1,0, 1, 1 (11 cycles).
- **Back-to-back:** `Data_Valid` held with 0xA5 then 0x3C, `PRESCALE`=2 → 0x3C accepted during frame 1 (`Data_Ready` low until frame 2 starts); the start bit of 0x3C follows the stop bit of 0xA5 with no idle cycle; `busy` never drops.
- **Reset mid-frame:** assert `RST` during the 4th data bit → `TX_OUT`=1, `busy`=0, `Data_Ready`=1 without a clock edge. After release, 0x55 transmits correctly.
- **Narrow width build:** `DATA_WIDTH`=5, `P_DATA`=0x13, even parity → 0, 1,1,0,0,1, 1, 1 (8 bits).

Source files
------------

// File: rtl/uart_tx_param.sv
// Prescaled UART transmitter: start, LSB-first data, optional parity, one or two stop bits.
// A one-word holding register lets the next frame follow the current one with no idle gap.
module uart_tx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      Data_Ready,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STP2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int IDX_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [IDX_WIDTH-1:0]      LAST_IDX  = IDX_WIDTH'(DATA_WIDTH - 1);
    localparam logic [IDX_WIDTH-1:0]      IDX_ONE   = IDX_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t state, state_next;

    logic                      hold_valid;
    logic [DATA_WIDTH-1:0]     hold_data;
    logic                      hold_par_en;
    logic                      hold_par_typ;
    logic                      hold_stp2;

    logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
    logic [IDX_WIDTH-1:0]      bit_idx, bit_idx_next;
    logic [PRESCALE_WIDTH-1:0] cnt, cnt_next;
    logic [PRESCALE_WIDTH-1:0] presc_reg, presc_next;
    logic                      par_bit, par_bit_next;
    logic                      frm_par_en, frm_par_en_next;
    logic                      frm_stp2, frm_stp2_next;
    logic                      tx_next, busy_next;
    logic                      load_frame, end_frame, bit_done;

    // Ready is simply "holding register empty", so accept and drain can never collide
    assign Data_Ready = ~hold_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
            hold_stp2    <= 1'b0;
        end else if (load_frame) begin
            hold_valid <= 1'b0;
        end else if (Data_Valid && Data_Ready) begin
            hold_valid   <= 1'b1;
            hold_data    <= P_DATA;
            hold_par_en  <= PAR_EN;
            hold_par_typ <= PAR_TYP;
            hold_stp2    <= STP2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
            presc_reg  <= PRESC_ONE;
            par_bit    <= 1'b0;
            frm_par_en <= 1'b0;
            frm_stp2   <= 1'b0;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_idx    <= bit_idx_next;
            cnt        <= cnt_next;
            presc_reg  <= presc_next;
            par_bit    <= par_bit_next;
            frm_par_en <= frm_par_en_next;
            frm_stp2   <= frm_stp2_next;
            TX_OUT     <= tx_next;
            busy       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state;
        shift_next      = shift_reg;
        bit_idx_next    = bit_idx;
        presc_next      = presc_reg;
        par_bit_next    = par_bit;
        frm_par_en_next = frm_par_en;
        frm_stp2_next   = frm_stp2;
        load_frame      = 1'b0;
        end_frame       = 1'b0;
        tx_next         = 1'b1;
        busy_next       = 1'b0;
        bit_done        = (cnt == presc_reg - PRESC_ONE);

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load_frame = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_IDX) begin
                        state_next = frm_par_en ? PARITY : STOP1;
                    end else begin
                        bit_idx_next = bit_idx + IDX_ONE;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP1;
                end
            end
            STOP1: begin
                if (bit_done) begin
                    if (frm_stp2) begin
                        state_next = STOP2;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_done) begin
                    end_frame = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A pending word at end of frame goes straight to START so frames abut
        if (end_frame) begin
            if (hold_valid) begin
                load_frame = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end

        if (load_frame) begin
            state_next      = START;
            shift_next      = hold_data;
            bit_idx_next    = '0;
            par_bit_next    = (^hold_data) ^ hold_par_typ;
            frm_par_en_next = hold_par_en;
            frm_stp2_next   = hold_stp2;
            presc_next      = (PRESCALE == '0) ? PRESC_ONE : PRESCALE;
        end

        cnt_next = (state == IDLE || bit_done) ? '0 : cnt + PRESC_ONE;

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: directed frames, random frames, back-to-back,
// reset mid-frame and a DATA_WIDTH=5 build, all compared against a bit-list frame model.
module tb_uart_tx_param;

    logic       CLK_tb = 1'b0;
    logic       rst_tb;
    logic [7:0] p_data8;
    logic       valid8, ready8, tx8, busy8;
    logic [4:0] p_data5;
    logic       valid5, ready5, tx5, busy5;
    logic       par_en, par_typ, stp2;
    logic [5:0] prescale;

    int   checks = 0;
    int   errors = 0;
    logic exp_tx[$];

    always #5 CLK_tb = ~CLK_tb;

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(CLK_tb), .RST(rst_tb), .P_DATA(p_data8), .Data_Valid(valid8),
        .Data_Ready(ready8), .PAR_EN(par_en), .PAR_TYP(par_typ), .STP2(stp2),
        .PRESCALE(prescale), .TX_OUT(tx8), .busy(busy8)
    );

    uart_tx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) dut5 (
        .CLK(CLK_tb), .RST(rst_tb), .P_DATA(p_data5), .Data_Valid(valid5),
        .Data_Ready(ready5), .PAR_EN(par_en), .PAR_TYP(par_typ), .STP2(stp2),
        .PRESCALE(prescale), .TX_OUT(tx5), .busy(busy5)
    );

    function automatic logic obsTx(input bit narrow);
        return narrow ? tx5 : tx8;
    endfunction

    function automatic logic obsBusy(input bit narrow);
        return narrow ? busy5 : busy8;
    endfunction

    function automatic logic obsReady(input bit narrow);
        return narrow ? ready5 : ready8;
    endfunction

    // Reference frame: list of line levels, each repeated P cycles
    function automatic void appendFrame(input logic [8:0] data, input int width, input logic pe,
                                        input logic pt, input logic s2, input int presc);
        int   p    = (presc == 0) ? 1 : presc;
        int   ones = 0;
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < width; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int r = 0; r < p; r++) exp_tx.push_back(bits[b]);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit narrow, input logic [8:0] data, input logic pe,
                                 input logic pt, input logic s2, input logic [5:0] presc);
        exp_tx.delete();
        appendFrame(data, narrow ? 5 : 8, pe, pt, s2, int'(presc));
        @(negedge CLK_tb);
        par_en   = pe;
        par_typ  = pt;
        stp2     = s2;
        prescale = presc;
        if (narrow) begin
            p_data5 = data[4:0];
            valid5  = 1'b1;
        end else begin
            p_data8 = data[7:0];
            valid8  = 1'b1;
        end
        checkOutput("ready before accept", obsReady(narrow), 1'b1);
        @(negedge CLK_tb);
        valid5  = 1'b0;
        valid8  = 1'b0;
        p_data8 = 8'($urandom);
        p_data5 = 5'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        stp2    = 1'($urandom);
        checkOutput("ready after accept", obsReady(narrow), 1'b0);
        checkOutput("tx before start", obsTx(narrow), 1'b1);
        checkOutput("busy before start", obsBusy(narrow), 1'b0);
        foreach (exp_tx[c]) begin
            @(negedge CLK_tb);
            if (c == 0) prescale = 6'($urandom);
            checkOutput($sformatf("tx cycle %0d", c), obsTx(narrow), exp_tx[c]);
            checkOutput($sformatf("busy cycle %0d", c), obsBusy(narrow), 1'b1);
            checkOutput($sformatf("ready cycle %0d", c), obsReady(narrow), 1'b1);
        end
        @(negedge CLK_tb);
        checkOutput("tx after frame", obsTx(narrow), 1'b1);
        checkOutput("busy after frame", obsBusy(narrow), 1'b0);
    endtask

    initial begin
        int len1;
        rst_tb   = 1'b1;
        p_data8  = '0;
        p_data5  = '0;
        valid8   = 1'b0;
        valid5   = 1'b0;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stp2     = 1'b0;
        prescale = 6'd1;
        #1;
        checkOutput("reset tx", tx8, 1'b1);
        checkOutput("reset busy", busy8, 1'b0);
        checkOutput("reset ready", ready8, 1'b1);
        checkOutput("reset tx narrow", tx5, 1'b1);
        checkOutput("reset busy narrow", busy5, 1'b0);
        checkOutput("reset ready narrow", ready5, 1'b1);
        repeat (2) @(negedge CLK_tb);
        rst_tb = 1'b0;

        $display("[TB] directed frames");
        applyStimulus(1'b0, 9'h078, 1'b1, 1'b0, 1'b0, 6'd1);
        applyStimulus(1'b0, 9'h070, 1'b1, 1'b1, 1'b0, 6'd4);
        applyStimulus(1'b0, 9'h060, 1'b0, 1'b0, 1'b1, 6'd0);
        applyStimulus(1'b1, 9'h013, 1'b1, 1'b0, 1'b0, 6'd1);

        $display("[TB] back-to-back frames");
        exp_tx.delete();
        appendFrame(9'h0A5, 8, 1'b1, 1'b0, 1'b0, 2);
        len1 = exp_tx.size();
        appendFrame(9'h03C, 8, 1'b1, 1'b0, 1'b0, 2);
        @(negedge CLK_tb);
        par_en   = 1'b1;
        par_typ  = 1'b0;
        stp2     = 1'b0;
        prescale = 6'd2;
        p_data8  = 8'hA5;
        valid8   = 1'b1;
        @(negedge CLK_tb);
        p_data8 = 8'h3C;
        checkOutput("b2b ready after first accept", ready8, 1'b0);
        foreach (exp_tx[c]) begin
            @(negedge CLK_tb);
            if (c == 1) valid8 = 1'b0;
            checkOutput($sformatf("b2b tx cycle %0d", c), tx8, exp_tx[c]);
            checkOutput($sformatf("b2b busy cycle %0d", c), busy8, 1'b1);
            checkOutput($sformatf("b2b ready cycle %0d", c), ready8, (c == 0) || (c >= len1));
        end
        @(negedge CLK_tb);
        checkOutput("b2b tx idle", tx8, 1'b1);
        checkOutput("b2b busy idle", busy8, 1'b0);

        $display("[TB] reset mid-frame");
        exp_tx.delete();
        appendFrame(9'h055, 8, 1'b1, 1'b0, 1'b0, 2);
        @(negedge CLK_tb);
        prescale = 6'd2;
        p_data8  = 8'h55;
        valid8   = 1'b1;
        @(negedge CLK_tb);
        valid8 = 1'b0;
        for (int c = 0; c <= 8; c++) @(negedge CLK_tb);
        checkOutput("tx in 4th data bit", tx8, exp_tx[8]);
        checkOutput("busy in 4th data bit", busy8, 1'b1);
        #2 rst_tb = 1'b1;
        #1;
        checkOutput("async reset tx", tx8, 1'b1);
        checkOutput("async reset busy", busy8, 1'b0);
        checkOutput("async reset ready", ready8, 1'b1);
        @(negedge CLK_tb);
        rst_tb = 1'b0;
        applyStimulus(1'b0, 9'h055, 1'b1, 1'b0, 1'b0, 6'd2);

        $display("[TB] random frames");
        for (int n = 0; n < 10; n++) begin
            applyStimulus((n % 4) == 3, 9'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 6'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
